dac_sample_fifo: RTL and testbench

//  Elastic buffer directly upstream of the codec serial interface. Accepts 32-bit stereo

---
 rtl/codec_pkg.sv | 17 +
 rtl/fifo_mem32.sv | 24 ++
 rtl/dac_sample_fifo.sv | 119 +++++++++++
 tb/tb_dac_sample_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared constants for the codec datapath: audio word geometry and the
// output-buffer state encoding.
package codec_pkg;

    localparam int AUDIO_WORD_W = 32;
    localparam int SAMPLE_W     = 16;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Left sample occupies the upper half and is shifted out first.
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_word_t;

endpackage

// File: rtl/fifo_mem32.sv
// DEPTH x 32 storage for the DAC sample FIFO: one synchronous write port,
// asynchronous read of the head entry.
module fifo_mem32
    import codec_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [$clog2(DEPTH)-1:0]  waddr_i,
    input  logic [AUDIO_WORD_W-1:0]   wdata_i,
    input  logic [$clog2(DEPTH)-1:0]  raddr_i,
    output logic [AUDIO_WORD_W-1:0]   rdata_o
);

    logic [AUDIO_WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dac_sample_fifo.sv
// Elastic buffer feeding the codec serial interface: primes to a fill
// threshold, then hands one word per LR frame, playing silence on underrun.
module dac_sample_fifo
    import codec_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int START_LEVEL = 4,
    parameter int UNDER_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [AUDIO_WORD_W-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      frame_strobe,
    output logic [AUDIO_WORD_W-1:0]   dac_data_out,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      running,
    output logic [UNDER_W-1:0]        underrun_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] START_LV = LW'(START_LEVEL);
    localparam logic [LW-1:0] FULL_LV  = LW'(DEPTH);

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [0:0]              state_q, state_d;
    logic [AUDIO_WORD_W-1:0] dout_q, dout_d;
    logic [UNDER_W-1:0]      under_q, under_d;
    logic [AUDIO_WORD_W-1:0] head;
    logic                    push, pop;

    assign in_ready = (level_q != FULL_LV) && !flush && !reset;
    assign push     = in_valid && in_ready;

    fifo_mem32 #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Threshold and empty tests use the registered level, so a word pushed
    // in the strobe cycle cannot be popped in that same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        state_d  = state_q;
        dout_d   = dout_q;
        under_d  = under_q;
        pop      = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            state_d  = ST_PRIME;
            dout_d   = '0;
        end else begin
            if (frame_strobe) begin
                if (state_q == ST_PRIME) begin
                    if (level_q >= START_LV) begin
                        dout_d  = head;
                        pop     = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        dout_d  = '0;
                    end
                end else begin
                    if (level_q != '0) begin
                        dout_d  = head;
                        pop     = 1'b1;
                    end else begin
                        dout_d  = '0;
                        state_d = ST_PRIME;
                        if (under_q != '1) under_d = under_q + 1'b1;
                    end
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_PRIME;
            dout_q   <= '0;
            under_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            dout_q   <= dout_d;
            under_q  <= under_d;
        end
    end

    assign dac_data_out = dout_q;
    assign level        = level_q;
    assign running      = (state_q == ST_RUN);
    assign underrun_cnt = under_q;

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed bench for dac_sample_fifo; a second small instance exercises
// underrun counter saturation within a short run.
module tb_dac_sample_fifo;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, frame_strobe;
    logic [31:0] in_data;
    logic        in_ready, running;
    logic [31:0] dac_data_out;
    logic [4:0]  level;
    logic [15:0] underrun_cnt;

    logic        b_reset, b_flush, b_valid, b_strobe;
    logic [31:0] b_data;
    logic        b_ready, b_running;
    logic [31:0] b_dout;
    logic [2:0]  b_level;
    logic [2:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_sample_fifo dut (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .frame_strobe(frame_strobe),
        .dac_data_out(dac_data_out), .level(level), .running(running),
        .underrun_cnt(underrun_cnt)
    );

    dac_sample_fifo #(.DEPTH(4), .START_LEVEL(1), .UNDER_W(3)) dut_b (
        .clk(clk), .reset(b_reset), .flush(b_flush), .in_data(b_data),
        .in_valid(b_valid), .in_ready(b_ready), .frame_strobe(b_strobe),
        .dac_data_out(b_dout), .level(b_level), .running(b_running),
        .underrun_cnt(b_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic strobe();
        frame_strobe = 1'b1;
        cyc();
        frame_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; frame_strobe = 1'b0; in_data = '0;
        b_reset = 1'b1; b_flush = 1'b0; b_valid = 1'b0; b_strobe = 1'b0; b_data = '0;
        cyc(); cyc();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_dout", dac_data_out, 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_cnt", 32'(underrun_cnt), 32'd0);
        reset = 1'b0; b_reset = 1'b0;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);

        // 1: strobes with nothing stored stay silent in PRIME
        strobe(); strobe(); strobe();
        chk("t1_dout", dac_data_out, 32'd0);
        chk("t1_running", 32'(running), 32'd0);
        chk("t1_cnt", 32'(underrun_cnt), 32'd0);
        chk("t1_ready", 32'(in_ready), 32'd1);

        // 2: prime to 4, then play
        for (int n = 1; n <= 4; n++) push(32'hA000_0000 + 32'(n));
        chk("t2_level4", 32'(level), 32'd4);
        strobe();
        chk("t2_dout_a1", dac_data_out, 32'hA000_0001);
        chk("t2_running", 32'(running), 32'd1);
        chk("t2_level3", 32'(level), 32'd3);
        strobe();
        chk("t2_dout_a2", dac_data_out, 32'hA000_0002);
        strobe();
        chk("t2_dout_a3", dac_data_out, 32'hA000_0003);
        chk("t2_level1", 32'(level), 32'd1);

        // 4: last word, then underrun, then re-prime below threshold
        strobe();
        chk("t4_dout_a4", dac_data_out, 32'hA000_0004);
        chk("t4_level0", 32'(level), 32'd0);
        strobe();
        chk("t4_dout_silent", dac_data_out, 32'd0);
        chk("t4_cnt1", 32'(underrun_cnt), 32'd1);
        chk("t4_running0", 32'(running), 32'd0);
        for (int n = 1; n <= 3; n++) push(32'hB000_0000 + 32'(n));
        strobe();
        chk("t4_prime_dout", dac_data_out, 32'd0);
        chk("t4_prime_run", 32'(running), 32'd0);
        chk("t4_prime_level", 32'(level), 32'd3);

        // 3: fill to full, overflow attempt, pop from full
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("t3_flush_level", 32'(level), 32'd0);
        for (int n = 0; n < 16; n++) push(32'hC000_0000 + 32'(n));
        chk("t3_full_level", 32'(level), 32'd16);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        push(32'hDEAD_BEEF);
        chk("t3_no_overflow", 32'(level), 32'd16);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; frame_strobe = 1'b1;
        cyc();
        chk("t3_popfull_level", 32'(level), 32'd15);
        chk("t3_popfull_dout", dac_data_out, 32'hC000_0000);
        in_data = 32'hE000_0001;
        cyc();
        in_valid = 1'b0; frame_strobe = 1'b0;
        chk("t3_pushpop_level", 32'(level), 32'd15);
        chk("t3_pushpop_dout", dac_data_out, 32'hC000_0001);

        // 5: flush beats coincident push and strobe
        flush = 1'b1; cyc(); flush = 1'b0;
        for (int n = 0; n < 5; n++) push(32'hF000_0000 + 32'(n));
        strobe();
        chk("t5_pre_dout", dac_data_out, 32'hF000_0000);
        push(32'hF000_0005);
        chk("t5_pre_level", 32'(level), 32'd5);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678; frame_strobe = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0; frame_strobe = 1'b0;
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_dout", dac_data_out, 32'd0);
        chk("t5_running", 32'(running), 32'd0);
        chk("t5_cnt", 32'(underrun_cnt), 32'd1);

        // 6a: saturation on the 3-bit counter instance
        for (int i = 0; i < 9; i++) begin
            b_valid = 1'b1; b_data = 32'h5000_0000 + 32'(i);
            cyc();
            b_valid = 1'b0; b_strobe = 1'b1;
            cyc();
            cyc();
            b_strobe = 1'b0;
            chk("t6_sat_cnt", 32'(b_cnt), (i < 7) ? 32'(i + 1) : 32'd7);
        end
        chk("t6_sat_running", 32'(b_running), 32'd0);
        chk("t6_sat_level", 32'(b_level), 32'd0);
        chk("t6_sat_dout", b_dout, 32'd0);
        chk("t6_sat_ready", 32'(b_ready), 32'd1);

        // 6b: reset in the middle of RUN
        for (int n = 0; n < 4; n++) push(32'h6000_0000 + 32'(n));
        strobe();
        chk("t6_run_pre", 32'(running), 32'd1);
        reset = 1'b1; in_valid = 1'b1; frame_strobe = 1'b1; flush = 1'b1;
        #1;
        chk("t6_ready_in_rst", 32'(in_ready), 32'd0);
        cyc();
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_dout", dac_data_out, 32'd0);
        chk("t6_rst_running", 32'(running), 32'd0);
        chk("t6_rst_cnt", 32'(underrun_cnt), 32'd0);
        reset = 1'b0; in_valid = 1'b0; frame_strobe = 1'b0; flush = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
